iob_pcie_chnl_host: RTL and testbench
=====================================

Name: iob_pcie_chnl_host

Overview:
- Channel-side peer of a RIFFA-style user core; drives the core's CHNL_RX transaction and sinks its CHNL_TX transaction.
- Bench/loopback endpoint in the iob-pcie subsystem. Lets a local controller push a word stream into a user channel and collect the channel's reply, without the PCIe engine.
- Send side has a small FWFT word buffer. Receive side is a stream pass-through with beat counting.

Parameters:
- C_PCI_DATA_WIDTH, 32, channel data width in bits (32/64/128); beat = C_PCI_DATA_WIDTH/32 words.
- FIFO_DEPTH_LOG2, 4, log2 of send-buffer depth in beats.
- ACK_TIMEOUT, 1024, cycles to wait for CHNL_RX_ACK before aborting.

Ports:
- CLK in 1: single clock, also the channel clock.
- RST in 1: synchronous, active-high reset.
- SEND_START in 1: pulse; starts an RX transaction.
- SEND_LEN in 32: transaction length in 32-bit words.
- SEND_OFF in 31: offset forwarded on CHNL_RX_OFF.
- SEND_LAST in 1: forwarded on CHNL_RX_LAST.
- SEND_BUSY out 1: send FSM not idle.
- SEND_DONE out 1: one-cycle pulse on completion.
- SEND_ERR out 1: one-cycle pulse on ack timeout.
- WDATA in C_PCI_DATA_WIDTH: beat to send.
- WVALID in 1: push request for WDATA.
- WREADY out 1: buffer not full.
- CHNL_RX out 1; CHNL_RX_ACK in 1; CHNL_RX_LAST out 1; CHNL_RX_LEN out 32; CHNL_RX_OFF out 31; CHNL_RX_DATA out C_PCI_DATA_WIDTH; CHNL_RX_DATA_VALID out 1; CHNL_RX_DATA_REN in 1.
- CHNL_TX in 1; CHNL_TX_ACK out 1; CHNL_TX_LAST in 1; CHNL_TX_LEN in 32; CHNL_TX_OFF in 31; CHNL_TX_DATA in C_PCI_DATA_WIDTH; CHNL_TX_DATA_VALID in 1; CHNL_TX_DATA_REN out 1.
- RDATA out C_PCI_DATA_WIDTH: received beat (= CHNL_TX_DATA).
- RVALID out 1: received beat valid.
- RREADY in 1: consumer accepts beat.
- RECV_LEN out 32: words received in the last TX transaction.
- RECV_DONE out 1: one-cycle pulse at end of a TX transaction.

Behaviour:
- Reset (synchronous): both FSMs idle; buffer emptied; all counters zero.
  - All outputs 0 except WREADY=1.
  - CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_LAST and RECV_LEN read 0.
  - RST mid-transaction aborts immediately, with no DONE or ERR pulse.
- Send FSM states: S_IDLE, S_REQ, S_DATA.
  - S_IDLE, on SEND_START:
    - SEND_LEN==0: SEND_DONE pulses the next cycle; CHNL_RX is never raised.
    - Otherwise: latch LEN/OFF/LAST, clear the word count and timeout counter, go to S_REQ. CHNL_RX is high from the next cycle.
    - SEND_START is ignored outside S_IDLE.
  - S_REQ: CHNL_RX=1, timeout counter increments each cycle.
    - CHNL_RX_ACK=1 → S_DATA.
    - Counter reaches ACK_TIMEOUT-1 without ack → SEND_ERR pulse, CHNL_RX drops, S_IDLE.
  - S_DATA: CHNL_RX stays high.
    - CHNL_RX_DATA_VALID = buffer not empty; CHNL_RX_DATA = buffer head.
    - A beat transfers when VALID&REN; the count then advances by C_PCI_DATA_WIDTH/32.
    - When the post-increment count >= latched LEN: the following cycle has CHNL_RX=0 and a SEND_DONE pulse, then S_IDLE.
    - Surplus buffered beats remain for the next transaction.
  - SEND_BUSY = state != S_IDLE.
- Send buffer:
  - Push on WVALID&WREADY, allowed in any state.
  - Pop only on CHNL_RX_DATA_VALID&CHNL_RX_DATA_REN.
  - WREADY = !full, from registered flags, so no push is accepted at full even if a pop happens in the same cycle.
  - Simultaneous push and pop when neither full nor empty leaves the occupancy unchanged.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2.
- Receive FSM states: R_IDLE, R_DATA.
  - R_IDLE, on CHNL_TX: latch CHNL_TX_LEN, clear the count, CHNL_TX_ACK=1 for exactly one cycle, go to R_DATA.
  - R_DATA:
    - CHNL_TX_DATA_REN = RREADY; RVALID = CHNL_TX_DATA_VALID; RDATA = CHNL_TX_DATA (combinational).
    - On VALID&REN the count advances by C_PCI_DATA_WIDTH/32.
    - When count >= latched LEN, or CHNL_TX deasserts: RECV_LEN ← count, RECV_DONE pulses, R_IDLE.
    - A zero-length TX completes one cycle after the ack with RECV_LEN=0.
- The send and receive sides run independently; both may be active in the same cycle.
- Counts are 32-bit unsigned and saturate at 32'hFFFFFFFF.

Decomposition:
- Shared package iob_pcie_pkg: send/receive state encodings, beat-word constant (C_PCI_DATA_WIDTH/32).
- Sub-module iob_pcie_fifo_fwft:
  - Parameterised width and log2 depth.
  - Ports: push/pop/full/empty/head.
  - Instantiated once for the send buffer.

Test Plan:
- Push 4 beats 0x11..0x44, SEND_START with LEN=4; peer acks on cycle 2 and holds REN=1 → 4 beats in order on CHNL_RX_DATA, CHNL_RX drops after the 4th, one SEND_DONE, SEND_BUSY returns to 0.
- SEND_START with LEN=3 and no ack, ACK_TIMEOUT=16 → CHNL_RX high for 16 cycles, then one SEND_ERR pulse, no SEND_DONE.
- Push 16 beats (depth 16) → WREADY=0 after the 16th; push attempted at full with a simultaneous pop → occupancy 15, no data lost.
- Peer raises CHNL_TX with LEN=5 and words 1..5, RREADY toggling 1/0 → CHNL_TX_ACK one cycle, RDATA 1..5 in order, RECV_LEN=5, one RECV_DONE.
- Peer raises CHNL_TX with LEN=8 and drops it after 3 beats → RECV_LEN=3, RECV_DONE pulse.
- RST asserted mid-S_DATA after 2 of 6 beats → next cycle CHNL_RX=0, buffer empty, WREADY=1, no DONE/ERR; a fresh LEN=1 send then completes normally.

Source files
------------

// File: rtl/iob_pcie_pkg.sv
// rtl/iob_pcie_pkg.sv - shared state encodings and count helpers for the iob-pcie channel host
package iob_pcie_pkg;

  localparam int unsigned WORD_BITS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } send_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } recv_state_e;

  // Words carried by one channel beat.
  function automatic logic [31:0] beat_words(input int unsigned width);
    return 32'(width / WORD_BITS);
  endfunction

  // Word counts stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/iob_pcie_fifo_fwft.sv
// rtl/iob_pcie_fifo_fwft.sv - first-word-fall-through buffer with registered occupancy flags
module iob_pcie_fifo_fwft #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  // Flags come straight from the occupancy register, so a pop never opens room in its own cycle.
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/iob_pcie_chnl_host.sv
// rtl/iob_pcie_chnl_host.sv - channel-side peer: buffered CHNL_RX sender and CHNL_TX sink
module iob_pcie_chnl_host
  import iob_pcie_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT      = 1024
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        SEND_START,
  input  logic [31:0]                 SEND_LEN,
  input  logic [30:0]                 SEND_OFF,
  input  logic                        SEND_LAST,
  output logic                        SEND_BUSY,
  output logic                        SEND_DONE,
  output logic                        SEND_ERR,
  input  logic [C_PCI_DATA_WIDTH-1:0] WDATA,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic                        CHNL_RX,
  input  logic                        CHNL_RX_ACK,
  output logic                        CHNL_RX_LAST,
  output logic [31:0]                 CHNL_RX_LEN,
  output logic [30:0]                 CHNL_RX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  output logic                        CHNL_RX_DATA_VALID,
  input  logic                        CHNL_RX_DATA_REN,
  input  logic                        CHNL_TX,
  output logic                        CHNL_TX_ACK,
  input  logic                        CHNL_TX_LAST,
  input  logic [31:0]                 CHNL_TX_LEN,
  input  logic [30:0]                 CHNL_TX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  input  logic                        CHNL_TX_DATA_VALID,
  output logic                        CHNL_TX_DATA_REN,
  output logic [C_PCI_DATA_WIDTH-1:0] RDATA,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [31:0]                 RECV_LEN,
  output logic                        RECV_DONE
);

  localparam logic [31:0] BEAT_WORDS   = beat_words(C_PCI_DATA_WIDTH);
  localparam logic [31:0] TIMEOUT_LAST = ACK_TIMEOUT - 1;
  localparam logic [31:0] ONE          = 32'd1;

  send_state_e                 send_state_q;
  logic [31:0]                 send_len_q;
  logic [30:0]                 send_off_q;
  logic                        send_last_q;
  logic [31:0]                 send_cnt_q;
  logic [31:0]                 send_cnt_d;
  logic [31:0]                 tmo_cnt_q;
  logic                        chnl_rx_q;
  logic                        send_done_q;
  logic                        send_err_q;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [C_PCI_DATA_WIDTH-1:0] fifo_head;
  logic                        rx_fire;

  recv_state_e recv_state_q;
  logic [31:0] recv_tgt_q;
  logic [31:0] recv_cnt_q;
  logic [31:0] recv_len_q;
  logic        tx_ack_q;
  logic        recv_done_q;
  logic        tx_fire;
  logic        unused_tx_meta;

  assign unused_tx_meta = ^{CHNL_TX_LAST, CHNL_TX_OFF};

  iob_pcie_fifo_fwft #(
    .WIDTH      (C_PCI_DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_send_buf (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (WVALID),
    .data_i  (WDATA),
    .pop_i   (rx_fire),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign WREADY             = !fifo_full;
  assign CHNL_RX_DATA_VALID = (send_state_q == S_DATA) && !fifo_empty;
  assign CHNL_RX_DATA       = (send_state_q == S_DATA) ? fifo_head : '0;
  assign rx_fire            = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
  assign send_cnt_d         = sat_add(send_cnt_q, BEAT_WORDS);

  assign SEND_BUSY    = (send_state_q != S_IDLE);
  assign SEND_DONE    = send_done_q;
  assign SEND_ERR     = send_err_q;
  assign CHNL_RX      = chnl_rx_q;
  assign CHNL_RX_LEN  = send_len_q;
  assign CHNL_RX_OFF  = send_off_q;
  assign CHNL_RX_LAST = send_last_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      send_state_q <= S_IDLE;
      send_len_q   <= '0;
      send_off_q   <= '0;
      send_last_q  <= 1'b0;
      send_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      chnl_rx_q    <= 1'b0;
      send_done_q  <= 1'b0;
      send_err_q   <= 1'b0;
    end else begin
      send_done_q <= 1'b0;
      send_err_q  <= 1'b0;
      case (send_state_q)
        S_IDLE: begin
          if (SEND_START) begin
            if (SEND_LEN == '0) begin
              send_done_q <= 1'b1;
            end else begin
              send_len_q   <= SEND_LEN;
              send_off_q   <= SEND_OFF;
              send_last_q  <= SEND_LAST;
              send_cnt_q   <= '0;
              tmo_cnt_q    <= '0;
              chnl_rx_q    <= 1'b1;
              send_state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // An ack arriving on the final timeout cycle still wins.
          if (CHNL_RX_ACK) begin
            send_state_q <= S_DATA;
          end else if (tmo_cnt_q >= TIMEOUT_LAST) begin
            send_err_q   <= 1'b1;
            chnl_rx_q    <= 1'b0;
            send_state_q <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + ONE;
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            send_cnt_q <= send_cnt_d;
            if (send_cnt_d >= send_len_q) begin
              chnl_rx_q    <= 1'b0;
              send_done_q  <= 1'b1;
              send_state_q <= S_IDLE;
            end
          end
        end
        default: begin
          chnl_rx_q    <= 1'b0;
          send_state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign CHNL_TX_DATA_REN = (recv_state_q == R_DATA) && RREADY;
  assign RVALID           = (recv_state_q == R_DATA) && CHNL_TX_DATA_VALID;
  assign RDATA            = (recv_state_q == R_DATA) ? CHNL_TX_DATA : '0;
  assign tx_fire          = RVALID && RREADY;
  assign CHNL_TX_ACK      = tx_ack_q;
  assign RECV_LEN         = recv_len_q;
  assign RECV_DONE        = recv_done_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      recv_state_q <= R_IDLE;
      recv_tgt_q   <= '0;
      recv_cnt_q   <= '0;
      recv_len_q   <= '0;
      tx_ack_q     <= 1'b0;
      recv_done_q  <= 1'b0;
    end else begin
      tx_ack_q    <= 1'b0;
      recv_done_q <= 1'b0;
      case (recv_state_q)
        R_IDLE: begin
          if (CHNL_TX) begin
            recv_tgt_q   <= CHNL_TX_LEN;
            recv_cnt_q   <= '0;
            tx_ack_q     <= 1'b1;
            recv_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          // The peer dropping CHNL_TX early ends the transfer with whatever arrived.
          if ((recv_cnt_q >= recv_tgt_q) || !CHNL_TX) begin
            recv_len_q   <= recv_cnt_q;
            recv_done_q  <= 1'b1;
            recv_state_q <= R_IDLE;
          end else if (tx_fire) begin
            recv_cnt_q <= sat_add(recv_cnt_q, BEAT_WORDS);
          end
        end
        default: recv_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_pcie_chnl_host.sv
// tb/tb_iob_pcie_chnl_host.sv - randomized directed bench for iob_pcie_chnl_host with a queue model
module tb_iob_pcie_chnl_host;

  localparam int DW    = 32;
  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam int TMO   = 16;
  localparam int BW    = DW / 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          SEND_START;
  logic [31:0]   SEND_LEN;
  logic [30:0]   SEND_OFF;
  logic          SEND_LAST;
  logic          SEND_BUSY;
  logic          SEND_DONE;
  logic          SEND_ERR;
  logic [DW-1:0] WDATA;
  logic          WVALID;
  logic          WREADY;
  logic          CHNL_RX;
  logic          CHNL_RX_ACK;
  logic          CHNL_RX_LAST;
  logic [31:0]   CHNL_RX_LEN;
  logic [30:0]   CHNL_RX_OFF;
  logic [DW-1:0] CHNL_RX_DATA;
  logic          CHNL_RX_DATA_VALID;
  logic          CHNL_RX_DATA_REN;
  logic          CHNL_TX;
  logic          CHNL_TX_ACK;
  logic          CHNL_TX_LAST;
  logic [31:0]   CHNL_TX_LEN;
  logic [30:0]   CHNL_TX_OFF;
  logic [DW-1:0] CHNL_TX_DATA;
  logic          CHNL_TX_DATA_VALID;
  logic          CHNL_TX_DATA_REN;
  logic [DW-1:0] RDATA;
  logic          RVALID;
  logic          RREADY;
  logic [31:0]   RECV_LEN;
  logic          RECV_DONE;

  always #5 CLK = ~CLK;

  iob_pcie_chnl_host #(
    .C_PCI_DATA_WIDTH (DW),
    .FIFO_DEPTH_LOG2  (DL2),
    .ACK_TIMEOUT      (TMO)
  ) dut (
    .CLK (CLK), .RST (RST),
    .SEND_START (SEND_START), .SEND_LEN (SEND_LEN), .SEND_OFF (SEND_OFF), .SEND_LAST (SEND_LAST),
    .SEND_BUSY (SEND_BUSY), .SEND_DONE (SEND_DONE), .SEND_ERR (SEND_ERR),
    .WDATA (WDATA), .WVALID (WVALID), .WREADY (WREADY),
    .CHNL_RX (CHNL_RX), .CHNL_RX_ACK (CHNL_RX_ACK), .CHNL_RX_LAST (CHNL_RX_LAST),
    .CHNL_RX_LEN (CHNL_RX_LEN), .CHNL_RX_OFF (CHNL_RX_OFF), .CHNL_RX_DATA (CHNL_RX_DATA),
    .CHNL_RX_DATA_VALID (CHNL_RX_DATA_VALID), .CHNL_RX_DATA_REN (CHNL_RX_DATA_REN),
    .CHNL_TX (CHNL_TX), .CHNL_TX_ACK (CHNL_TX_ACK), .CHNL_TX_LAST (CHNL_TX_LAST),
    .CHNL_TX_LEN (CHNL_TX_LEN), .CHNL_TX_OFF (CHNL_TX_OFF), .CHNL_TX_DATA (CHNL_TX_DATA),
    .CHNL_TX_DATA_VALID (CHNL_TX_DATA_VALID), .CHNL_TX_DATA_REN (CHNL_TX_DATA_REN),
    .RDATA (RDATA), .RVALID (RVALID), .RREADY (RREADY),
    .RECV_LEN (RECV_LEN), .RECV_DONE (RECV_DONE)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_send_done = 0, n_send_err = 0, n_recv_done = 0, n_tx_ack = 0;
  logic [DW-1:0] sq[$];

  always @(negedge CLK) begin
    if (SEND_DONE === 1'b1)   n_send_done++;
    if (SEND_ERR === 1'b1)    n_send_err++;
    if (RECV_DONE === 1'b1)   n_recv_done++;
    if (CHNL_TX_ACK === 1'b1) n_tx_ack++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    WDATA  = d;
    WVALID = 1'b1;
    #1;
    check("push_wready", 32'(WREADY), 32'(sq.size() < DEPTH));
    if (sq.size() < DEPTH) sq.push_back(d);
    step();
    WVALID = 1'b0;
  endtask

  task automatic run_send(input logic [31:0] len, input bit do_ack, input bit rand_ren,
                          input bit push_on_pop, input string tag);
    int rx_high = 0;
    int beats   = 0;
    int d0      = n_send_done;
    int e0      = n_send_err;
    int occ0;
    bit v;
    logic [30:0] off;
    logic        last;
    off  = 31'($urandom);
    last = 1'($urandom_range(0, 1));
    SEND_LEN   = len;
    SEND_OFF   = off;
    SEND_LAST  = last;
    SEND_START = 1'b1;
    step();
    SEND_START = 1'b0;
    for (int cyc = 0; cyc < 300 && CHNL_RX; cyc++) begin
      rx_high++;
      CHNL_RX_ACK      = do_ack && (rx_high > 1);
      CHNL_RX_DATA_REN = rand_ren ? 1'($urandom_range(0, 1)) : 1'b1;
      v      = CHNL_RX_DATA_VALID;
      occ0   = sq.size();
      WVALID = push_on_pop && v && CHNL_RX_DATA_REN;
      WDATA  = $urandom;
      #1;
      if (rx_high == 1) check({tag, "_valid_in_req"}, 32'(v), 0);
      if (WVALID) begin
        check({tag, "_wready_on_pop"}, 32'(WREADY), 32'(occ0 < DEPTH));
        if (occ0 < DEPTH) sq.push_back(WDATA);
      end
      if (v && CHNL_RX_DATA_REN) begin
        if (sq.size() == 0) check({tag, "_spurious_valid"}, 32'(v), 0);
        else check({tag, "_data"}, CHNL_RX_DATA, sq.pop_front());
        beats++;
      end
      step();
      WVALID = 1'b0;
    end
    CHNL_RX_ACK      = 1'b0;
    CHNL_RX_DATA_REN = 1'b0;
    check({tag, "_rx_low"}, 32'(CHNL_RX), 0);
    step();
    check({tag, "_beats"}, beats, (do_ack && len != 0) ? (int'(len) + BW - 1) / BW : 0);
    if (len == 0)     check({tag, "_rx_cycles"}, rx_high, 0);
    else if (!do_ack) check({tag, "_rx_cycles"}, rx_high, TMO);
    check({tag, "_done_pulses"}, n_send_done - d0, 32'((len == 0) || do_ack));
    check({tag, "_err_pulses"}, n_send_err - e0, 32'((len != 0) && !do_ack));
    check({tag, "_done_width"}, 32'(SEND_DONE), 0);
    check({tag, "_busy"}, 32'(SEND_BUSY), 0);
    if (len != 0) begin
      check({tag, "_rx_len"}, CHNL_RX_LEN, len);
      check({tag, "_rx_off"}, 32'(CHNL_RX_OFF), 32'(off));
      check({tag, "_rx_last"}, 32'(CHNL_RX_LAST), 32'(last));
    end
  endtask

  task automatic run_recv(input logic [31:0] len, input int n_beats, input bit rand_mode,
                          input string tag);
    logic [DW-1:0] words[$];
    int idx  = 0;
    int d0   = n_recv_done;
    int a0   = n_tx_ack;
    int wcyc = 0;
    bit rr   = 1'b1;
    for (int i = 0; i < n_beats; i++) words.push_back(rand_mode ? DW'($urandom) : DW'(i + 1));
    CHNL_TX      = 1'b1;
    CHNL_TX_LEN  = len;
    CHNL_TX_OFF  = 31'($urandom);
    CHNL_TX_LAST = 1'b1;
    step();
    while (CHNL_TX_ACK !== 1'b1 && wcyc < 20) begin
      step();
      wcyc++;
    end
    check({tag, "_ack_seen"}, 32'(CHNL_TX_ACK), 1);
    step();
    for (int cyc = 0; cyc < 200 && idx < n_beats; cyc++) begin
      CHNL_TX_DATA       = words[idx];
      CHNL_TX_DATA_VALID = 1'b1;
      RREADY             = rr;
      rr                 = rand_mode ? 1'($urandom_range(0, 1)) : !rr;
      #1;
      check({tag, "_ren"}, 32'(CHNL_TX_DATA_REN), 32'(RREADY));
      if (RREADY) begin
        check({tag, "_rvalid"}, 32'(RVALID), 1);
        check({tag, "_rdata"}, RDATA, words[idx]);
        idx++;
      end
      step();
    end
    CHNL_TX            = 1'b0;
    CHNL_TX_DATA_VALID = 1'b0;
    RREADY             = 1'b0;
    wcyc = 0;
    while (n_recv_done == d0 && wcyc < 10) begin
      step();
      wcyc++;
    end
    step();
    check({tag, "_done_pulses"}, n_recv_done - d0, 1);
    check({tag, "_recv_len"}, RECV_LEN, 32'(n_beats * BW));
    check({tag, "_ack_pulses"}, n_tx_ack - a0, 1);
    check({tag, "_rvalid_idle"}, 32'(RVALID), 0);
  endtask

  initial begin
    int n;
    int beats;
    int d0;
    int e0;
    RST = 1'b1; SEND_START = 1'b0; SEND_LEN = '0; SEND_OFF = '0; SEND_LAST = 1'b0;
    WDATA = '0; WVALID = 1'b0; CHNL_RX_ACK = 1'b0; CHNL_RX_DATA_REN = 1'b0;
    CHNL_TX = 1'b0; CHNL_TX_LEN = '0; CHNL_TX_OFF = '0; CHNL_TX_LAST = 1'b0;
    CHNL_TX_DATA = '0; CHNL_TX_DATA_VALID = 1'b0; RREADY = 1'b0;
    step();
    step();
    check("rst_wready", 32'(WREADY), 1);
    check("rst_busy", 32'(SEND_BUSY), 0);
    check("rst_chnl_rx", 32'(CHNL_RX), 0);
    check("rst_rx_len", CHNL_RX_LEN, 0);
    check("rst_rx_off", 32'(CHNL_RX_OFF), 0);
    check("rst_rx_last", 32'(CHNL_RX_LAST), 0);
    check("rst_rx_valid", 32'(CHNL_RX_DATA_VALID), 0);
    check("rst_tx_ack", 32'(CHNL_TX_ACK), 0);
    check("rst_rvalid", 32'(RVALID), 0);
    check("rst_recv_len", RECV_LEN, 0);
    check("rst_pulses", {29'd0, SEND_DONE, SEND_ERR, RECV_DONE}, 0);
    RST = 1'b0;
    step();

    for (int i = 1; i <= 4; i++) push_word(DW'(i * 'h11));
    run_send(32'd4, 1'b1, 1'b0, 1'b0, "send4");
    check("send4_model_empty", sq.size(), 0);

    run_send(32'd0, 1'b1, 1'b0, 1'b0, "send0");
    run_send(32'd3, 1'b0, 1'b0, 1'b0, "timeout");

    for (int i = 0; i < DEPTH; i++) push_word($urandom);
    check("full_wready", 32'(WREADY), 0);
    run_send(32'd1, 1'b1, 1'b0, 1'b1, "pop_at_full");
    check("occ_after_pop", sq.size(), DEPTH - 1);
    push_word($urandom);
    check("refull_wready", 32'(WREADY), 0);
    run_send(32'(DEPTH), 1'b1, 1'b1, 1'b0, "drain16");

    for (int i = 0; i < 5; i++) push_word($urandom);
    run_send(32'd3, 1'b1, 1'b1, 1'b0, "surplus_a");
    run_send(32'd2, 1'b1, 1'b1, 1'b0, "surplus_b");
    n = $urandom_range(1, 12);
    for (int i = 0; i < n; i++) push_word($urandom);
    run_send(32'(n), 1'b1, 1'b1, 1'b0, "rand_send");

    run_recv(32'd5, 5, 1'b0, "recv5");
    run_recv(32'd8, 3, 1'b0, "recv_drop");
    run_recv(32'd0, 0, 1'b0, "recv0");
    n = $urandom_range(1, 10);
    run_recv(32'(n), n, 1'b1, "rand_recv");

    for (int i = 0; i < 6; i++) push_word($urandom);
    d0 = n_send_done;
    e0 = n_send_err;
    beats = 0;
    SEND_LEN = 32'd6; SEND_OFF = '0; SEND_LAST = 1'b0; SEND_START = 1'b1;
    step();
    SEND_START = 1'b0;
    for (int cyc = 0; cyc < 50 && beats < 2; cyc++) begin
      CHNL_RX_ACK      = 1'b1;
      CHNL_RX_DATA_REN = 1'b1;
      #1;
      if (CHNL_RX_DATA_VALID) begin
        check("rst_mid_data", CHNL_RX_DATA, sq.pop_front());
        beats++;
      end
      step();
    end
    check("rst_mid_beats", beats, 2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    CHNL_RX_ACK = 1'b0;
    CHNL_RX_DATA_REN = 1'b0;
    sq.delete();
    check("rst_mid_chnl_rx", 32'(CHNL_RX), 0);
    check("rst_mid_wready", 32'(WREADY), 1);
    check("rst_mid_busy", 32'(SEND_BUSY), 0);
    check("rst_mid_valid", 32'(CHNL_RX_DATA_VALID), 0);
    step();
    check("rst_mid_no_done", n_send_done - d0, 0);
    check("rst_mid_no_err", n_send_err - e0, 0);
    push_word($urandom);
    run_send(32'd1, 1'b1, 1'b0, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
